seg_scan_display: RTL and testbench



---
 rtl/display_pkg.sv | 32 +++
 rtl/seven_seg_decoder.sv | 35 +++
 rtl/seg_scan_display.sv | 211 +++++++++++++++++++++
 tb/tb_seg_scan_display.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared definitions for the multiplexed seven-segment scanner:
// active-high segment glyphs (seg[0]=a .. seg[6]=g) and the scan state encoding.
package display_pkg;

    // All segments dark, in the active-high internal form.
    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Hex glyphs, active-high, bit order {g,f,e,d,c,b,a}.
    localparam logic [6:0] GLYPH_0 = 7'h3F;
    localparam logic [6:0] GLYPH_1 = 7'h06;
    localparam logic [6:0] GLYPH_2 = 7'h5B;
    localparam logic [6:0] GLYPH_3 = 7'h4F;
    localparam logic [6:0] GLYPH_4 = 7'h66;
    localparam logic [6:0] GLYPH_5 = 7'h6D;
    localparam logic [6:0] GLYPH_6 = 7'h7D;
    localparam logic [6:0] GLYPH_7 = 7'h07;
    localparam logic [6:0] GLYPH_8 = 7'h7F;
    localparam logic [6:0] GLYPH_9 = 7'h6F;
    localparam logic [6:0] GLYPH_A = 7'h77;
    localparam logic [6:0] GLYPH_B = 7'h7C;  // lower-case b
    localparam logic [6:0] GLYPH_C = 7'h39;
    localparam logic [6:0] GLYPH_D = 7'h5E;  // lower-case d
    localparam logic [6:0] GLYPH_E = 7'h79;
    localparam logic [6:0] GLYPH_F = 7'h71;

    // Scan FSM: BLANK = all anodes off between digits, DRIVE = one digit lit.
    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } scan_state_t;

endpackage

// File: rtl/seven_seg_decoder.sv
// Hex nibble to seven-segment pattern, active-high internal form.
// Polarity for the board pins is applied by the instantiating scanner.
module seven_seg_decoder
    import display_pkg::*;
(
    input  logic [3:0] i_hex,
    output logic [6:0] o_seg
);

    // Pure lookup of the glyph for the incoming nibble.
    always_comb begin
        // NOTE: a default assignment ahead of the case keeps this block free of latches.
        o_seg = SEG_BLANK;
        case (i_hex)
            4'h0: o_seg = GLYPH_0;
            4'h1: o_seg = GLYPH_1;
            4'h2: o_seg = GLYPH_2;
            4'h3: o_seg = GLYPH_3;
            4'h4: o_seg = GLYPH_4;
            4'h5: o_seg = GLYPH_5;
            4'h6: o_seg = GLYPH_6;
            4'h7: o_seg = GLYPH_7;
            4'h8: o_seg = GLYPH_8;
            4'h9: o_seg = GLYPH_9;
            4'hA: o_seg = GLYPH_A;
            4'hB: o_seg = GLYPH_B;
            4'hC: o_seg = GLYPH_C;
            4'hD: o_seg = GLYPH_D;
            4'hE: o_seg = GLYPH_E;
            4'hF: o_seg = GLYPH_F;
            default: o_seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg_scan_display.sv
// Multiplexed seven-segment scanner for NUM_DIGITS hex digits.
// Each digit is driven for REFRESH_DIV cycles, separated by BLANK_CYCLES of
// all-anodes-off to suppress ghosting. New values land in a shadow register
// and are copied to the active buffer only at the frame boundary, so a frame
// never mixes old and new data. All pins are registered.
// Optional build macro SEG_SCAN_LZ_SUPPRESS_EN enables leading-zero blanking.
module seg_scan_display
    import display_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 2,
    parameter int ACTIVE_LOW   = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   en_in,
    input  logic                    load,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_done
);

    localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CNT_MAX = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);

    // Pin values for "off". XOR with these converts the active-high internal
    // form to pin polarity, so inversion lives only at the output register.
    localparam logic [6:0]            SEG_OFF = (ACTIVE_LOW != 0) ? 7'h7F : SEG_BLANK;
    localparam logic [NUM_DIGITS-1:0] AN_OFF  = (ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : '0;
    localparam logic                  DP_OFF  = (ACTIVE_LOW != 0);

    // Scan state.
    scan_state_t               r_state;
    logic [IDX_W-1:0]          r_idx;
    logic [CNT_W-1:0]          r_cnt;

    // Shadow (written by load) and active (displayed) buffers.
    logic [4*NUM_DIGITS-1:0]   r_shadow_dig;
    logic [NUM_DIGITS-1:0]     r_shadow_dp;
    logic [NUM_DIGITS-1:0]     r_shadow_en;
    logic                      r_pending;
    logic [4*NUM_DIGITS-1:0]   r_act_dig;
    logic [NUM_DIGITS-1:0]     r_act_dp;
    logic [NUM_DIGITS-1:0]     r_act_en;

    // Registered pins.
    logic [6:0]                r_seg;
    logic                      r_dp;
    logic [NUM_DIGITS-1:0]     r_an;
    logic                      r_frame_done;

    // Next-state values; outputs are computed from these so pins move on the
    // same edge as the state/index change.
    scan_state_t               w_state_nxt;
    logic [IDX_W-1:0]          w_idx_nxt;
    logic [CNT_W-1:0]          w_cnt_nxt;
    logic                      w_wrap;
    logic [4*NUM_DIGITS-1:0]   w_act_dig_nxt;
    logic [NUM_DIGITS-1:0]     w_act_dp_nxt;
    logic [NUM_DIGITS-1:0]     w_act_en_nxt;
    logic [NUM_DIGITS-1:0]     w_lz_mask;
    logic [NUM_DIGITS-1:0]     w_en_eff;
    logic [3:0]                w_nib;
    logic                      w_dp_sel;
    logic                      w_en_sel;
    logic                      w_show;
    logic [6:0]                w_seg_dec;
    logic [6:0]                w_seg_hi;
    logic                      w_dp_hi;
    logic [NUM_DIGITS-1:0]     w_an_hi;

    // Dwell counting and BLANK/DRIVE sequencing, including the digit-index wrap.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_cnt_nxt   = r_cnt + CNT_W'(1);
        w_wrap      = 1'b0;
        case (r_state)
            ST_BLANK: begin
                if (BLANK_CYCLES == 0 || r_cnt == BLANK_LAST) begin
                    w_state_nxt = ST_DRIVE;
                    w_cnt_nxt   = '0;
                end
            end
            ST_DRIVE: begin
                if (r_cnt == DRIVE_LAST) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = (BLANK_CYCLES == 0) ? ST_DRIVE : ST_BLANK;
                    if (r_idx == IDX_LAST) begin
                        w_idx_nxt = '0;
                        w_wrap    = 1'b1;
                    end else begin
                        w_idx_nxt = r_idx + IDX_W'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = ST_BLANK;
                w_idx_nxt   = '0;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // The active buffer picks up the pending shadow exactly at the wrap.
    assign w_act_dig_nxt = (w_wrap && r_pending) ? r_shadow_dig : r_act_dig;
    assign w_act_dp_nxt  = (w_wrap && r_pending) ? r_shadow_dp  : r_act_dp;
    assign w_act_en_nxt  = (w_wrap && r_pending) ? r_shadow_en  : r_act_en;

`ifdef SEG_SCAN_LZ_SUPPRESS_EN
    logic w_lz_run;

    // Blank zero digits from the top down until a non-zero nibble or a lit dp; digit 0 always shows.
    always_comb begin
        w_lz_mask = '0;
        w_lz_run  = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            w_lz_run     = w_lz_run & (w_act_dig_nxt[4*i +: 4] == 4'h0) & ~w_act_dp_nxt[i];
            w_lz_mask[i] = w_lz_run;
        end
    end
`else
    assign w_lz_mask = '0;
`endif

    assign w_en_eff = w_act_en_nxt & ~w_lz_mask;

    // Select nibble, dp and enable of the digit that will be driven next.
    always_comb begin
        w_nib    = 4'h0;
        w_dp_sel = 1'b0;
        w_en_sel = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (w_idx_nxt == IDX_W'(i)) begin
                w_nib    = w_act_dig_nxt[4*i +: 4];
                w_dp_sel = w_act_dp_nxt[i];
                w_en_sel = w_en_eff[i];
            end
        end
    end

    seven_seg_decoder u_decoder (
        .i_hex (w_nib),
        .o_seg (w_seg_dec)
    );

    // A blanked digit still uses its slot, but anode, segments and dp stay dark.
    assign w_show   = (w_state_nxt == ST_DRIVE) && w_en_sel;
    assign w_seg_hi = w_show ? w_seg_dec : SEG_BLANK;
    assign w_dp_hi  = w_show & w_dp_sel;
    assign w_an_hi  = w_show ? (NUM_DIGITS'(1) << w_idx_nxt) : '0;

    // Scan FSM, buffers and registered pins; synchronous reset aborts any frame in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_BLANK;
            r_idx        <= '0;
            r_cnt        <= '0;
            r_shadow_dig <= '0;
            r_shadow_dp  <= '0;
            r_shadow_en  <= '0;
            r_pending    <= 1'b0;
            r_act_dig    <= '0;
            r_act_dp     <= '0;
            r_act_en     <= '0;
            r_seg        <= SEG_OFF;
            r_dp         <= DP_OFF;
            r_an         <= AN_OFF;
            r_frame_done <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values.
            r_state      <= w_state_nxt;
            r_idx        <= w_idx_nxt;
            r_cnt        <= w_cnt_nxt;
            r_act_dig    <= w_act_dig_nxt;
            r_act_dp     <= w_act_dp_nxt;
            r_act_en     <= w_act_en_nxt;
            r_frame_done <= w_wrap;

            if (w_wrap && r_pending) begin
                r_pending <= 1'b0;
            end
            // A load on the boundary edge is written after the transfer, so it waits a frame.
            if (load) begin
                r_shadow_dig <= digits_in;
                r_shadow_dp  <= dp_in;
                r_shadow_en  <= en_in;
                r_pending    <= 1'b1;
            end

            r_seg <= w_seg_hi ^ SEG_OFF;
            r_dp  <= w_dp_hi ^ DP_OFF;
            r_an  <= w_an_hi ^ AN_OFF;
        end
    end

    assign seg        = r_seg;
    assign dp         = r_dp;
    assign an         = r_an;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seg_scan_display.sv
// Directed bench for seg_scan_display with NUM_DIGITS=4, REFRESH_DIV=4,
// BLANK_CYCLES=1, ACTIVE_LOW=1 (20-cycle frame). Frame position k counts
// clock edges after a frame boundary: k=1..4 digit 0, k=5 blank, ...,
// k=16..19 digit 3, k=20 blank with frame_done.
module tb_seg_scan_display;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] digits_in;
    logic [3:0]  dp_in;
    logic [3:0]  en_in;
    logic        load;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        frame_done;

    int total = 0;
    int bad   = 0;

    // Active-low pin patterns for hex 0..F, written out by hand.
    logic [6:0] glyph_al [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    localparam logic [12:0] ALL_OFF = {4'b1111, 7'h7F, 1'b1, 1'b0};

    always #5 clk = ~clk;

    seg_scan_display #(
        .NUM_DIGITS   (4),
        .REFRESH_DIV  (4),
        .BLANK_CYCLES (1),
        .ACTIVE_LOW   (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .digits_in  (digits_in),
        .dp_in      (dp_in),
        .en_in      (en_in),
        .load       (load),
        .seg        (seg),
        .dp         (dp),
        .an         (an),
        .frame_done (frame_done)
    );

    // Expected {an, seg, dp, frame_done} at frame position k.
    // cfg = {dp[3:0], lit[3:0], value[15:0]}; lit is the set of digits that should show.
    function automatic logic [12:0] exp_vec(input int k, input logic [23:0] cfg);
        int         pos;
        int         d;
        logic       fd;
        logic [3:0] onehot;
        logic [3:0] nib;
        pos    = (k - 1) % 5;
        d      = (k - 1) / 5;
        fd     = (k == 20);
        if (pos == 4 || !cfg[16 + d]) return {4'b1111, 7'h7F, 1'b1, fd};
        onehot = 4'b0001 << d;
        nib    = cfg[4*d +: 4];
        return {~onehot, glyph_al[nib], ~cfg[20 + d], fd};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Advance one edge, pulsing load with l1/l2 when k matches l1_k/l2_k.
    task automatic frame_step(input int k, input int l1_k, input logic [23:0] l1,
                              input int l2_k, input logic [23:0] l2);
        load = 1'b0;
        if (k == l1_k) begin
            load = 1'b1;
            {dp_in, en_in, digits_in} = l1;
        end else if (k == l2_k) begin
            load = 1'b1;
            {dp_in, en_in, digits_in} = l2;
        end
        step();
        load = 1'b0;
    endtask

    task automatic test_reset();
        logic [12:0] obs;
        rst = 1'b1;
        load = 1'b0;
        digits_in = 16'h0000;
        dp_in = 4'h0;
        en_in = 4'h0;
        for (int i = 0; i < 3; i++) begin
            step();
            obs = {an, seg, dp, frame_done};
            total++;
            if (obs !== ALL_OFF) begin
                bad++;
                $display("FAIL reset cyc=%0d got=%h want=%h", i, obs, ALL_OFF);
            end
        end
        rst = 1'b0;
    endtask

    // First frame after reset is dark (active buffer cleared) and frame_done
    // lands at exactly k=20; 12AF is loaded mid-frame and shown the frame after.
    task automatic test_basic_scan();
        logic [12:0] obs;
        logic [12:0] exp;
        for (int k = 1; k <= 20; k++) begin
            frame_step(k, 5, 24'h0F_12AF, -1, 24'h0);
            obs = {an, seg, dp, frame_done};
            exp = exp_vec(k, 24'h00_0000);
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL post_reset_frame k=%0d got=%h want=%h", k, obs, exp);
            end
        end
        for (int k = 1; k <= 20; k++) begin
            frame_step(k, -1, 24'h0, -1, 24'h0);
            obs = {an, seg, dp, frame_done};
            exp = exp_vec(k, 24'h0F_12AF);
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL basic_scan k=%0d got=%h want=%h", k, obs, exp);
            end
        end
    endtask

    // Mid-frame load of 0000 must not tear the 12AF frame; 5555 loaded on the
    // boundary edge waits a frame while the old shadow (0000) is shown.
    task automatic test_tear_free_boundary();
        logic [12:0] obs;
        logic [12:0] exp;
        for (int k = 1; k <= 20; k++) begin
            frame_step(k, 8, 24'h0F_0000, 20, 24'h0F_5555);
            obs = {an, seg, dp, frame_done};
            exp = exp_vec(k, 24'h0F_12AF);
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL tear_free k=%0d got=%h want=%h", k, obs, exp);
            end
        end
        for (int k = 1; k <= 20; k++) begin
            frame_step(k, -1, 24'h0, -1, 24'h0);
            obs = {an, seg, dp, frame_done};
            exp = exp_vec(k, 24'h0F_0000);
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL boundary_old k=%0d got=%h want=%h", k, obs, exp);
            end
        end
    endtask

    // 5555 finally appears; two loads in the same frame, the later (2222) wins.
    task automatic test_back_to_back();
        logic [12:0] obs;
        logic [12:0] exp;
        for (int k = 1; k <= 20; k++) begin
            frame_step(k, 3, 24'h0F_1111, 12, 24'h0F_2222);
            obs = {an, seg, dp, frame_done};
            exp = exp_vec(k, 24'h0F_5555);
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL boundary_new k=%0d got=%h want=%h", k, obs, exp);
            end
        end
        for (int k = 1; k <= 20; k++) begin
            frame_step(k, 5, 24'h15_12AF, -1, 24'h0);
            obs = {an, seg, dp, frame_done};
            exp = exp_vec(k, 24'h0F_2222);
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL last_load_wins k=%0d got=%h want=%h", k, obs, exp);
            end
        end
    endtask

    // en=0101, dp=0001: digits 1 and 3 dark, dp lit only on digit 0. Then a
    // reset during digit 2 blanks the pins on that edge and the scan restarts.
    task automatic test_mask_reset();
        logic [12:0] obs;
        logic [12:0] exp;
        for (int k = 1; k <= 20; k++) begin
            frame_step(k, -1, 24'h0, -1, 24'h0);
            obs = {an, seg, dp, frame_done};
            exp = exp_vec(k, 24'h15_12AF);
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL mask_dp k=%0d got=%h want=%h", k, obs, exp);
            end
        end
        for (int k = 1; k <= 12; k++) begin
            frame_step(k, -1, 24'h0, -1, 24'h0);
            obs = {an, seg, dp, frame_done};
            exp = exp_vec(k, 24'h15_12AF);
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL mask_pre_rst k=%0d got=%h want=%h", k, obs, exp);
            end
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        obs = {an, seg, dp, frame_done};
        total++;
        if (obs !== ALL_OFF) begin
            bad++;
            $display("FAIL mid_frame_rst got=%h want=%h", obs, ALL_OFF);
        end
        for (int k = 1; k <= 20; k++) begin
            frame_step(k, 2, 24'h0F_12AF, -1, 24'h0);
            obs = {an, seg, dp, frame_done};
            exp = exp_vec(k, 24'h00_0000);
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL restart_frame k=%0d got=%h want=%h", k, obs, exp);
            end
        end
        for (int k = 1; k <= 20; k++) begin
            frame_step(k, 3, 24'h0F_0040, -1, 24'h0);
            obs = {an, seg, dp, frame_done};
            exp = exp_vec(k, 24'h0F_12AF);
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL restart_digit0 k=%0d got=%h want=%h", k, obs, exp);
            end
        end
    endtask

    // Leading zeros: suppressed when the macro is defined, shown otherwise.
    task automatic test_leading_zero();
        logic [12:0] obs;
        logic [12:0] exp;
        logic [23:0] cfg_0040;
        logic [23:0] cfg_0000;
`ifdef SEG_SCAN_LZ_SUPPRESS_EN
        cfg_0040 = 24'h03_0040;
        cfg_0000 = 24'h01_0000;
`else
        cfg_0040 = 24'h0F_0040;
        cfg_0000 = 24'h0F_0000;
`endif
        for (int k = 1; k <= 20; k++) begin
            frame_step(k, 3, 24'h0F_0000, -1, 24'h0);
            obs = {an, seg, dp, frame_done};
            exp = exp_vec(k, cfg_0040);
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL lz_0040 k=%0d got=%h want=%h", k, obs, exp);
            end
        end
        for (int k = 1; k <= 20; k++) begin
            frame_step(k, -1, 24'h0, -1, 24'h0);
            obs = {an, seg, dp, frame_done};
            exp = exp_vec(k, cfg_0000);
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL lz_0000 k=%0d got=%h want=%h", k, obs, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_scan();
        test_tear_free_boundary();
        test_back_to_back();
        test_mask_reset();
        test_leading_zero();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard stop in case the sequence above ever stalls.
    initial begin
        #100000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
